// File: rtl/combine_n.sv
// Packs N consecutive DW-bit input words into one registered N*DW-bit output group.
// Groups close when full, on din_last, or on a flush request; partial groups are zero-filled.
module combine_n #(
    parameter int DW        = 24,
    parameter int N         = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            din_valid,
    input  logic [DW-1:0]   din,
    input  logic            din_last,
    output logic            din_ready,
    input  logic            flush,
    output logic [N*DW-1:0] dout,
    output logic [N-1:0]    dout_keep,
    output logic            dout_last,
    output logic            dout_valid,
    input  logic            dout_ready
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0]   cnt;
    logic [DW-1:0]   acc [N];
    logic            flush_pend;

    logic            accept;
    logic            complete;
    logic            flush_now;
    logic            emit;
    logic [DW-1:0]   grp [N];
    logic [N-1:0]    grp_keep;
    logic [N*DW-1:0] grp_flat;

    assign din_ready = !dout_valid || dout_ready;
    assign accept    = din_valid && din_ready;
    assign complete  = accept && ((int'(cnt) == N - 1) || din_last);
    // A flush (new or pending) can only act when the output register is free.
    assign flush_now = din_ready && (flush_pend || flush);
    assign emit      = complete || (flush_now && (accept || cnt != '0));

    // Candidate group: accumulated words plus the word accepted this cycle.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            grp[i]      = (accept && int'(cnt) == i) ? din : acc[i];
            grp_keep[i] = (i < int'(cnt) + (accept ? 1 : 0));
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_slot
        if (MSB_FIRST != 0) begin : g_msb
            assign grp_flat[(N-g)*DW-1 -: DW] = grp[g];
        end else begin : g_lsb
            assign grp_flat[(g+1)*DW-1 -: DW] = grp[g];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            flush_pend <= 1'b0;
            dout       <= '0;
            dout_keep  <= '0;
            dout_last  <= 1'b0;
            dout_valid <= 1'b0;
            for (int i = 0; i < N; i++) acc[i] <= '0;
        end else if (emit) begin
            dout       <= grp_flat;
            dout_keep  <= grp_keep;
            dout_last  <= complete && din_last;
            dout_valid <= 1'b1;
            cnt        <= '0;
            flush_pend <= 1'b0;
            for (int i = 0; i < N; i++) acc[i] <= '0;
        end else begin
            if (dout_ready) dout_valid <= 1'b0;
            if (accept) begin
                for (int i = 0; i < N; i++) begin
                    if (int'(cnt) == i) acc[i] <= din;
                end
                cnt <= cnt + 1'b1;
            end
            if (flush_now)  flush_pend <= 1'b0;
            else if (flush) flush_pend <= 1'b1;
        end
    end

endmodule

// File: doc/combine_n.md
COMBINE_N -- requirements
Module: combine_n

Interface
REQ-001 SHALL provide parameter DW, default 24: input word width in bits, 1..256.
REQ-002 SHALL provide parameter N, default 2: words per output group, 1..16.
REQ-003 SHALL provide parameter MSB_FIRST, default 1: 1 = first word of a group in the top slot, 0 = first word in the bottom slot.
REQ-004 SHALL use one clock and a synchronous, active-high reset; ports clk and rst as below.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 din_valid  input  1  input word present.
REQ-008 din  input  DW  input word.
REQ-009 din_last  input  1  word closes the current group early; qualified by din_valid.
REQ-010 din_ready  output  1  block accepts din this cycle.
REQ-011 flush  input  1  single-cycle request to emit the pending partial group.
REQ-012 dout  output  N*DW  packed group, registered.
REQ-013 dout_keep  output  N  per-slot filled mask; bit i = slot i (word i of group).
REQ-014 dout_last  output  1  group closed by din_last.
REQ-015 dout_valid  output  1  dout/dout_keep/dout_last valid.
REQ-016 dout_ready  input  1  downstream accepts the output.

Function
REQ-017 Input accept SHALL occur on an edge where din_valid && din_ready; output transfer on an edge where dout_valid && dout_ready.
REQ-018 din_ready SHALL equal !dout_valid || dout_ready; it is combinational and independent of din_valid and din_last.
REQ-019 An accumulator SHALL hold up to N-1 words; a word counter cnt (0..N-1) SHALL give the slot of the next accepted word.
REQ-020 Slot i SHALL occupy dout bits [(N-i)*DW-1 : (N-1-i)*DW] when MSB_FIRST=1, and bits [(i+1)*DW-1 : i*DW] when MSB_FIRST=0.
REQ-021 An accept with cnt < N-1 and din_last=0 SHALL store din in slot cnt and increment cnt; outputs are unchanged.
REQ-022 An accept with cnt = N-1, or with din_last=1, SHALL complete the group, including din in slot cnt.
REQ-023 On completion, the output register SHALL load on the same edge; dout_valid SHALL rise one cycle after the accepting edge (latency 1); cnt SHALL return to 0.
REQ-024 On completion, dout_keep SHALL have bits 0..k-1 set, k = words in the group; unfilled slots of dout SHALL be zero; dout_last SHALL equal the din_last of the completing word.
REQ-025 A flush SHALL set a pending-flush flag; the flag SHALL be honoured on the first edge where the output register is free (!dout_valid || dout_ready).
REQ-026 Honouring a flush with cnt > 0 SHALL emit the partial group per REQ-024 with dout_last=0, then clear cnt.
REQ-027 Honouring a flush with cnt = 0 and no accept on that edge SHALL clear the flag and emit nothing.
REQ-028 A pending flush coinciding with an accept SHALL include the accepted word in the emitted group.
REQ-029 If that accepted word itself completes a group, the completion SHALL satisfy the flush, with a single emission.
REQ-030 dout_valid SHALL hold, with dout, dout_keep and dout_last stable, until an output transfer.
REQ-031 After an output transfer with no new load, dout_valid SHALL fall on that edge.
REQ-032 Load and output transfer on the same edge SHALL keep dout_valid=1 with the new group (back-to-back, no bubble).
REQ-033 N=1 SHALL degenerate to a one-stage registered pipe with dout_keep=1 on every output.
REQ-034 Sustained throughput SHALL be one input word per cycle while dout_ready=1.

Reset
REQ-035 During rst: dout=0, dout_keep=0, dout_last=0, dout_valid=0, cnt=0, accumulator=0, pending-flush=0; din_ready follows REQ-018 (1 after reset).
REQ-036 Reset mid-group or mid-stall SHALL discard all partial and held data; flush or din asserted in a reset cycle SHALL be ignored.

Verification
REQ-037 DW=24, N=2, MSB_FIRST=1, dout_ready=1: din 0x111111 then 0x222222 on consecutive cycles -> one cycle later dout=0x111111222222, dout_keep=2'b11, dout_last=0, one-cycle dout_valid pulse.
REQ-038 Same setup, dout_ready=0: four words 0xA1..0xA4 -> din_ready=0 once group 1 is held; raising dout_ready -> groups 0x0000A1_0000A2 then 0x0000A3_0000A4, none lost or duplicated.
REQ-039 DW=8, N=4, MSB_FIRST=0: din 0x11, then 0x22 with din_last=1 -> dout=0x00002211, dout_keep=4'b0011, dout_last=1; next group starts at slot 0.
REQ-040 DW=8, N=4: three words 0x01,0x02,0x03, then flush -> dout=0x01020300 (MSB_FIRST=1), dout_keep=4'b0111, dout_last=0; flush with cnt=0 -> no dout_valid.
REQ-041 Flush asserted while dout_valid=1 and dout_ready=0 -> partial group emitted the cycle after dout_ready rises; flush on the same cycle as the N-th accept -> exactly one group.
REQ-042 rst asserted after two of four words -> all outputs 0; next four words 0x05..0x08 -> dout=0x05060708, dout_keep=4'hF.
